// File: rtl/softmax_norm.sv
// Streaming softmax normaliser.
// Collects N Q4.4 exponent values and their sum, then emits each element
// divided by the sum as an unsigned Q0.OW probability. A single restoring
// divider is shared across elements and produces one quotient bit per clock.
module softmax_norm #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int OW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 zero_sum,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int SW = DW + IW;
    localparam int CW = $clog2(OW + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [CW-1:0] ITER_ONE  = CW'(1);
    localparam logic [CW-1:0] ITER_LAST = CW'(OW);

    logic [1:0]    state;
    logic [DW-1:0] buf_mem [N];
    logic [SW-1:0] sum;
    logic [IW-1:0] count;
    logic [IW-1:0] idx;
    logic [CW-1:0] iter;
    logic [SW:0]   rem;
    logic [OW-1:0] quo;

    logic [SW-1:0] sum_next;
    logic [SW-1:0] rem_diff;
    logic [SW:0]   rem_next;
    logic          q_bit;
    logic [OW:0]   quo_next;
    logic [IW-1:0] idx_next;
    logic          in_fire;
    logic          out_fire;

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_LOAD);
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == IDX_LAST);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign idx_next  = idx + IDX_ONE;

    // Accumulator update and one fractional restoring-division step. The
    // remainder starts at the element value and is doubled each step, so
    // OW+1 steps yield floor(elem * 2^OW / sum). Because rem < 2*sum, the
    // difference always fits in the sum width.
    always_comb begin
        sum_next = sum + {{IW{1'b0}}, in_data};
        q_bit    = (rem >= {1'b0, sum});
        rem_diff = rem[SW-1:0] - sum;
        rem_next = q_bit ? {rem_diff, 1'b0} : {rem[SW-1:0], 1'b0};
        quo_next = {quo, q_bit};
    end

    // Control FSM, operand buffer, accumulator and divider datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD;
            sum      <= '0;
            count    <= '0;
            idx      <= '0;
            iter     <= '0;
            rem      <= '0;
            quo      <= '0;
            out_data <= '0;
            zero_sum <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        buf_mem[count] <= in_data;
                        sum            <= sum_next;
                        count          <= count + IDX_ONE;
                        if (count == IDX_LAST) begin
                            state    <= S_DIV;
                            idx      <= '0;
                            iter     <= '0;
                            quo      <= '0;
                            rem      <= {{(SW + 1 - DW){1'b0}}, buf_mem[0]};
                            zero_sum <= (sum_next == '0);
                        end
                    end
                end
                S_DIV: begin
                    rem  <= rem_next;
                    quo  <= quo_next[OW-1:0];
                    iter <= iter + ITER_ONE;
                    if (iter == ITER_LAST) begin
                        state <= S_OUT;
                        if (zero_sum) begin
                            out_data <= '0;
                        end else if (quo_next[OW]) begin
                            out_data <= '1;
                        end else begin
                            out_data <= quo_next[OW-1:0];
                        end
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        if (idx == IDX_LAST) begin
                            state <= S_LOAD;
                            sum   <= '0;
                            count <= '0;
                            idx   <= '0;
                        end else begin
                            state <= S_DIV;
                            idx   <= idx_next;
                            iter  <= '0;
                            quo   <= '0;
                            rem   <= {{(SW + 1 - DW){1'b0}}, buf_mem[idx_next]};
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Self-checking bench for softmax_norm: table of directed vectors with
// hand-computed probabilities, plus backpressure, ignored-input and
// mid-division reset sequences.
module tb_softmax_norm;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_sum;
    logic       busy;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        string            name;
        logic [0:7][7:0]  data;
        logic [0:7][7:0]  expv;
        bit               zs;
        bit               gaps;
    } vec_t;

    vec_t tbl[6];

    softmax_norm #(.N(8), .DW(8), .OW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_sum  (zero_sum),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Feed one vector into the block, optionally with idle cycles between elements.
    // Returns at the negedge right after the edge that accepted the last element.
    task automatic applyStimulus(input logic [0:7][7:0] data, input bit gaps);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready before load", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = data[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Wait for out_valid with a bounded cycle budget.
    task automatic waitValid(input string name);
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) checkOutput({name, " out_valid timeout"}, out_valid, 1);
    endtask

    // Collect all eight outputs with out_ready held high and compare them.
    task automatic collectVector(input string name, input logic [0:7][7:0] expv, input bit zs);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            waitValid(name);
            checkOutput($sformatf("%s data[%0d]", name, i), out_data, expv[i]);
            checkOutput($sformatf("%s idx[%0d]", name, i), out_idx, i);
            checkOutput($sformatf("%s last[%0d]", name, i), out_last, (i == 7) ? 1 : 0);
            checkOutput($sformatf("%s zero_sum[%0d]", name, i), zero_sum, zs);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        int lat;
        logic [0:7][7:0] uni;
        logic [0:7][7:0] exp_uni;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        uni     = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        exp_uni = '{8'd32, 8'd32, 8'd32, 8'd32, 8'd32, 8'd32, 8'd32, 8'd32};

        tbl[0] = '{name: "uniform", data: uni, expv: exp_uni, zs: 1'b0, gaps: 1'b0};
        tbl[1] = '{name: "skewed",
                   data: '{8'h30, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00},
                   expv: '{8'd128, 8'd42, 8'd42, 8'd42, 8'd0, 8'd0, 8'd0, 8'd0},
                   zs: 1'b0, gaps: 1'b0};
        tbl[2] = '{name: "onehot",
                   data: '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   expv: '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                   zs: 1'b0, gaps: 1'b0};
        tbl[3] = '{name: "zeros",
                   data: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   expv: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                   zs: 1'b1, gaps: 1'b0};
        tbl[4] = '{name: "max",
                   data: '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                   expv: exp_uni, zs: 1'b0, gaps: 1'b0};
        tbl[5] = '{name: "skewed_gaps",
                   data: '{8'h30, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00},
                   expv: '{8'd128, 8'd42, 8'd42, 8'd42, 8'd0, 8'd0, 8'd0, 8'd0},
                   zs: 1'b0, gaps: 1'b1};

        // Reset values while reset is held.
        #12;
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_idx", out_idx, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset zero_sum", zero_sum, 0);
        checkOutput("reset busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors, with latency check on each.
        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %s", tbl[v].name);
            applyStimulus(tbl[v].data, tbl[v].gaps);
            checkOutput({tbl[v].name, " in_ready after last"}, in_ready, 0);
            checkOutput({tbl[v].name, " busy after last"}, busy, 1);
            lat = 0;
            while (!out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            checkOutput({tbl[v].name, " latency"}, lat, 9);
            collectVector(tbl[v].name, tbl[v].expv, tbl[v].zs);
            checkOutput({tbl[v].name, " in_ready after vector"}, in_ready, 1);
        end

        // Backpressure on idx 3, with in_valid pulses while busy.
        $display("[TB] backpressure and ignored input");
        applyStimulus(uni, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            waitValid("bp");
            checkOutput("bp in_ready busy", in_ready, 0);
            if (i == 3) begin
                for (int c = 0; c < 5; c++) begin
                    checkOutput("bp hold valid", out_valid, 1);
                    checkOutput("bp hold data", out_data, 32);
                    checkOutput("bp hold idx", out_idx, 3);
                    @(negedge clk);
                end
            end
            checkOutput($sformatf("bp data[%0d]", i), out_data, 32);
            checkOutput($sformatf("bp idx[%0d]", i), out_idx, i);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (i < 7) checkOutput("bp single output", out_valid, 0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        checkOutput("bp back to load", in_ready, 1);
        applyStimulus(uni, 1'b0);
        collectVector("after_bp", exp_uni, 1'b0);

        // Reset while dividing element 2.
        $display("[TB] reset during division");
        applyStimulus(uni, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            waitValid("rst");
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst pre busy", busy, 1);
        checkOutput("rst pre idx", out_idx, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rst in_ready", in_ready, 1);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_data", out_data, 0);
        checkOutput("rst out_idx", out_idx, 0);
        checkOutput("rst busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst released in_ready", in_ready, 1);
        applyStimulus(uni, 1'b0);
        collectVector("after_rst", exp_uni, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Streaming softmax normaliser that sits directly downstream of the exponent LUT stage.
- Collects a vector of N exponent values in Q4.4, accumulates their sum, then emits each element divided by the sum as a Q0.8 probability.
- Uses one shared sequential restoring divider, one quotient bit per cycle, with valid/ready handshakes on input and output.

Parameters:
- N, 8, vector length; power of two, at least 2.
- DW, 8, input width (Q4.4 exponent values).
- OW, 8, output fraction bits (Q0.OW).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element.
- in_data  input  DW  exponent value, Q4.4 unsigned.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OW  normalised probability, Q0.OW unsigned.
- out_idx  output  clog2(N)  element index of out_data.
- out_last  output  1  high with out_valid when out_idx == N-1.
- zero_sum  output  1  current vector summed to 0.
- busy  output  1  high in DIV or OUT.

Behaviour:
- Reset (async, rst_n low):
  - state = LOAD; in_ready = 1; out_valid = 0; out_data = 0; out_idx = 0; out_last = 0; zero_sum = 0; busy = 0.
  - Sum accumulator, load counter and buffer are cleared.
  - Reset mid-operation discards the vector in progress. The first cycle after release is LOAD with count 0.
- Storage: buffer of N×DW registers; sum register of DW+clog2(N) bits (11 bits at defaults). The sum cannot overflow.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready: buf[count] <= in_data, sum += in_data, count++.
  - The edge accepting element N-1 enters DIV for idx 0. in_ready is 0 from the next cycle.
  - in_valid while in_ready = 0 is ignored; nothing is latched.
- DIV:
  - On entry: remainder = 0, dividend = buf[idx] << OW, divisor = sum.
  - zero_sum is latched as (sum == 0) on entry and held until the next LOAD→DIV transition.
  - OW+1 iterations, one restoring step per clock, producing an (OW+1)-bit quotient q = floor(buf[idx]·2^OW / sum).
  - The edge performing the final iteration moves to OUT.
  - out_valid therefore rises exactly OW+1 (= 9) clocks after the edge that entered DIV.
- Output data:
  - out_data = (q > 2^OW−1) ? 2^OW−1 : q[OW−1:0]. Saturation occurs only when buf[idx] == sum.
  - If zero_sum = 1, out_data = 0 and the divider result is ignored.
- OUT:
  - out_valid = 1. out_data, out_idx and out_last are held stable until out_ready.
  - On out_valid && out_ready, if idx < N-1: idx++, enter DIV, out_valid = 0 next cycle.
  - On out_valid && out_ready, if idx == N-1: clear sum and count, idx = 0, enter LOAD, in_ready = 1 next cycle.
- No overlap between vectors: a new vector is not accepted until the last output handshake.
- busy = (state != LOAD).

Test Plan:
- Uniform: 8 × 0x10 (1.0) → sum = 128, eight outputs of 32 (0.125). out_idx runs 0..7, out_last only on idx 7, first out_valid 9 cycles after the last input accept.
- Skewed: [0x30, 0x10, 0x10, 0x10, 0, 0, 0, 0] → sum = 96, outputs [128, 42, 42, 42, 0, 0, 0, 0].
- Saturation / zero: one-hot [0x10, 0 ×7] → out 255 then 0 ×7. All zeros → eight outputs of 0 with zero_sum = 1 throughout, zero_sum = 0 on the next nonzero vector.
- Max: 8 × 0xFF → sum = 2040, every output is 32. Sum register shows no overflow.
- Backpressure/flow:
  - Hold out_ready low 5 cycles on idx 3 → out_data and out_idx stay stable, no extra outputs.
  - in_valid pulses during DIV/OUT are ignored.
  - Gaps in in_valid during LOAD give the same results as back-to-back input.
- Reset mid-DIV: assert rst_n low during idx 2 → all outputs take reset values immediately. After release, in_ready = 1 and a fresh uniform vector yields eight outputs of 32.
